// File: rtl/noc_link_arbiter.sv
// Wormhole arbiter for one output link shared by UP and NI, round-robin on heads, watchdog-closed worms.
// Latency 1 (registered output); inputs stall (ready=0) while the output register is full and out_ready=0.
module noc_link_arbiter #(
  parameter logic [5:0] HEAD_TAG = 6'b101111,
  parameter logic [7:0] TRAILER  = 8'hFF,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] current_node,
  input  logic       up_valid,
  input  logic [7:0] up_flit,
  output logic       up_ready,
  input  logic       ni_valid,
  input  logic [7:0] ni_flit,
  output logic       ni_ready,
  output logic       out_valid,
  output logic [7:0] out_flit,
  input  logic       out_ready,
  output logic       out_to_ni,
  output logic [1:0] owner,
  output logic       drop_pulse,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOCK_UP = 2'b01,
    S_LOCK_NI = 2'b10,
    S_FLUSH   = 2'b11
  } state_e;

  localparam logic RR_UP = 1'b0;
  localparam logic RR_NI = 1'b1;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_flit_q, out_flit_d;
  logic             out_to_ni_q, out_to_ni_d;
  logic             drop_q, drop_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  logic       can_load;
  logic       up_head, ni_head;
  logic       head_acc, drop_acc, sel_ni;
  logic       acc;
  logic [7:0] acc_flit;
  logic       own_valid;

  assign can_load  = !out_valid_q || out_ready;
  assign up_head   = up_valid && (up_flit[7:2] == HEAD_TAG);
  assign ni_head   = ni_valid && (ni_flit[7:2] == HEAD_TAG);
  assign acc       = (up_ready && up_valid) || (ni_ready && ni_valid);
  assign acc_flit  = ni_ready ? ni_flit : up_flit;
  assign own_valid = (state_q == S_LOCK_UP) ? up_valid : ni_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode: who may present a flit this cycle. In IDLE heads take
  // precedence over strays, so a stray never blocks a packet start.
  always_comb begin
    up_ready = 1'b0;
    ni_ready = 1'b0;
    head_acc = 1'b0;
    drop_acc = 1'b0;
    sel_ni   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (up_head || ni_head) begin
          sel_ni   = ni_head && (!up_head || rr_last_q == RR_UP);
          head_acc = can_load;
        end else if (up_valid || ni_valid) begin
          sel_ni   = ni_valid && (!up_valid || rr_last_q == RR_UP);
          drop_acc = can_load;
        end
        up_ready = (head_acc || drop_acc) && !sel_ni;
        ni_ready = (head_acc || drop_acc) && sel_ni;
      end
      S_LOCK_UP: up_ready = can_load;
      S_LOCK_NI: ni_ready = can_load;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    wd_d        = '0;
    terr_d      = 1'b0;
    drop_d      = drop_acc;
    out_valid_d = can_load ? 1'b0 : out_valid_q;
    out_flit_d  = out_flit_q;
    out_to_ni_d = out_to_ni_q;
    case (state_q)
      S_IDLE: begin
        if (head_acc) begin
          out_valid_d = 1'b1;
          out_flit_d  = acc_flit;
          rr_last_d   = sel_ni;
          out_to_ni_d = (acc_flit[1:0] == current_node);
          state_d     = sel_ni ? S_LOCK_NI : S_LOCK_UP;
        end
      end
      S_LOCK_UP, S_LOCK_NI: begin
        if (acc) begin
          out_valid_d = 1'b1;
          out_flit_d  = acc_flit;
        end
        // A closing TRAILER always beats the watchdog.
        if (acc && acc_flit == TRAILER) begin
          state_d     = S_IDLE;
          out_to_ni_d = 1'b0;
        end else if (!own_valid) begin
          if (wd_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_FLUSH;
            terr_d  = 1'b1;
          end else begin
            wd_d = wd_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_flit_d  = TRAILER;
          out_to_ni_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q   <= RR_NI;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_to_ni_q <= 1'b0;
      drop_q      <= 1'b0;
      terr_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_to_ni_q <= out_to_ni_d;
      drop_q      <= drop_d;
      terr_q      <= terr_d;
      wd_q        <= wd_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_flit    = out_flit_q;
  assign out_to_ni   = out_to_ni_q;
  assign owner       = state_q;
  assign drop_pulse  = drop_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Bench for noc_link_arbiter: directed scenarios plus randomized phases, each cycle compared
// against a packet-level reference model (owner, round-robin, watchdog, output register).
module tb_noc_link_arbiter;

  localparam logic [5:0] HEAD_TAG = 6'b101111;
  localparam logic [7:0] TRAILER  = 8'hFF;
  localparam int         TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] current_node = 2'd0;
  logic       up_valid = 1'b0;
  logic [7:0] up_flit = 8'h00;
  logic       up_ready;
  logic       ni_valid = 1'b0;
  logic [7:0] ni_flit = 8'h00;
  logic       ni_ready;
  logic       out_valid;
  logic [7:0] out_flit;
  logic       out_ready = 1'b1;
  logic       out_to_ni;
  logic [1:0] owner;
  logic       drop_pulse;
  logic       timeout_err;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: owner 0 none / 1 UP / 2 NI / 3 flush; m_rr = last granted requester.
  int         m_owner, m_rr, m_cnt;
  bit         m_ov, m_tn, m_drop, m_terr;
  logic [7:0] m_of;

  noc_link_arbiter dut (
    .clk(clk), .rst(rst), .current_node(current_node),
    .up_valid(up_valid), .up_flit(up_flit), .up_ready(up_ready),
    .ni_valid(ni_valid), .ni_flit(ni_flit), .ni_ready(ni_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .out_to_ni(out_to_ni), .owner(owner),
    .drop_pulse(drop_pulse), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = 0; m_rr = 2; m_cnt = 0;
    m_ov = 0; m_tn = 0; m_drop = 0; m_terr = 0; m_of = 8'h00;
  endtask

  // Called at a negedge: drive, compare against the model, advance the model, wait one cycle.
  task automatic step(input logic uv, input logic [7:0] uf, input logic nv,
                      input logic [7:0] nf, input logic ordy);
    int win;
    bit can, eu, en, uh, nh, acc, own_v;
    logic [7:0] af;
    up_valid = uv; up_flit = uf; ni_valid = nv; ni_flit = nf; out_ready = ordy;
    #1;
    can = !m_ov || ordy;
    uh  = uv && (uf[7:2] == HEAD_TAG);
    nh  = nv && (nf[7:2] == HEAD_TAG);
    eu = 0; en = 0; win = 0;
    if (m_owner == 0) begin
      if (uh || nh)      win = (uh && nh) ? ((m_rr == 1) ? 2 : 1) : (uh ? 1 : 2);
      else if (uv || nv) win = (uv && nv) ? ((m_rr == 1) ? 2 : 1) : (uv ? 1 : 2);
      if (can) begin eu = (win == 1); en = (win == 2); end
    end else if (m_owner == 1) eu = can;
    else if (m_owner == 2) en = can;

    chk("up_ready", up_ready, eu);
    chk("ni_ready", ni_ready, en);
    chk("out_valid", out_valid, m_ov);
    chk("out_flit", out_flit, m_of);
    chk("out_to_ni", out_to_ni, m_tn);
    chk("owner", owner, m_owner);
    chk("drop_pulse", drop_pulse, m_drop);
    chk("timeout_err", timeout_err, m_terr);

    acc = (eu && uv) || (en && nv);
    af  = eu ? uf : nf;
    m_drop = 0; m_terr = 0;
    if (can) m_ov = 0;
    if (m_owner == 0) begin
      if (acc && (uh || nh)) begin
        m_ov = 1; m_of = af; m_tn = (af[1:0] == current_node);
        m_rr = win; m_owner = win; m_cnt = 0;
      end else if (acc) m_drop = 1;
    end else if (m_owner == 3) begin
      if (can) begin m_ov = 1; m_of = TRAILER; m_tn = 0; m_owner = 0; end
    end else begin
      own_v = (m_owner == 1) ? uv : nv;
      if (acc) begin m_ov = 1; m_of = af; end
      if (acc && af == TRAILER) begin
        m_owner = 0; m_tn = 0; m_cnt = 0;
      end else if (own_v) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == TIMEOUT) begin m_owner = 3; m_terr = 1; m_cnt = 0; end
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_out_flit", out_flit, 8'h00);
    chk("rst_out_to_ni", out_to_ni, 1'b0);
    chk("rst_drop", drop_pulse, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    m_reset();
    up_valid = 1'b0; ni_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] gen_flit();
    int r;
    logic [1:0] d;
    r = int'($urandom_range(0, 9));
    d = 2'($urandom_range(0, 3));
    if (r < 4) return {HEAD_TAG, d};
    if (r < 6) return TRAILER;
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic int pick_prob();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 25;
      2: return 75;
      default: return 100;
    endcase
  endfunction

  initial begin
    int pu, pn, pr;
    m_reset();
    @(negedge clk);
    do_reset();

    // Contention after reset: UP first, NI waits for UP's trailer, then alternation.
    current_node = 2'd0;
    step(1, 8'hBC, 1, 8'hBE, 1); chk("t2_owner_up", owner, 2'b01); chk("t2_flit", out_flit, 8'hBC);
    step(1, 8'hFF, 1, 8'hBE, 1); chk("t2_release", owner, 2'b00);
    step(0, 8'h00, 1, 8'hBE, 1); chk("t2_owner_ni", owner, 2'b10); chk("t2_flit_ni", out_flit, 8'hBE);
    step(0, 8'h00, 1, 8'hFF, 1);
    step(1, 8'hBC, 1, 8'hBE, 1); chk("t2_rr_up", owner, 2'b01);
    step(1, 8'hFF, 0, 8'h00, 1);

    // Simple packet to this node.
    current_node = 2'd1;
    step(1, 8'hBD, 0, 8'h00, 1); chk("t1_f0", out_flit, 8'hBD); chk("t1_to_ni", out_to_ni, 1'b1);
    chk("t1_owner", owner, 2'b01);
    step(1, 8'h12, 0, 8'h00, 1); chk("t1_f1", out_flit, 8'h12);
    step(1, 8'h34, 0, 8'h00, 1); chk("t1_f2", out_flit, 8'h34);
    step(1, 8'hFF, 0, 8'h00, 1); chk("t1_f3", out_flit, 8'hFF); chk("t1_idle", owner, 2'b00);

    // Stray flit in IDLE.
    step(1, 8'h55, 0, 8'h00, 1); chk("t5_drop", drop_pulse, 1'b1); chk("t5_ov", out_valid, 1'b0);

    // Watchdog on a stalled NI owner.
    step(0, 8'h00, 1, 8'hBE, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 8'h00, 0, 8'h00, 1);
    chk("t3_no_early", timeout_err, 1'b0);
    step(0, 8'h00, 0, 8'h00, 1); chk("t3_terr", timeout_err, 1'b1); chk("t3_flush", owner, 2'b11);
    step(0, 8'h00, 0, 8'h00, 1); chk("t3_trailer", out_flit, 8'hFF); chk("t3_idle", owner, 2'b00);

    // Downstream backpressure mid-packet.
    step(1, 8'hBD, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h77, 0, 8'h00, 0);
      chk("t4_stable", out_flit, 8'hBD);
      chk("t4_no_terr", timeout_err, 1'b0);
    end
    step(1, 8'h77, 0, 8'h00, 1); chk("t4_flit", out_flit, 8'h77);
    step(1, 8'hFF, 0, 8'h00, 1);

    // Reset mid-packet, then a fresh head.
    step(0, 8'h00, 1, 8'hBE, 1);
    step(0, 8'h00, 1, 8'h21, 1);
    do_reset();
    step(1, 8'hBC, 0, 8'h00, 1); chk("t6_regrant", owner, 2'b01);
    step(1, 8'hFF, 0, 8'h00, 1);

    for (int p = 0; p < 60; p++) begin
      pu = pick_prob();
      pn = pick_prob();
      pr = ($urandom_range(0, 2) == 0) ? 40 : 90;
      current_node = 2'($urandom_range(0, 3));
      for (int c = 0; c < 40; c++)
        step(($urandom_range(0, 99) < pu), gen_flit(), ($urandom_range(0, 99) < pn),
             gen_flit(), ($urandom_range(0, 99) < pr));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
